// File: rtl/dcache1_puke_sched_pkg.sv
// Shared definitions for the dcache1 puke (set invalidation) scheduler.
//   PUKE_PORTS   : puke write ports per tag way (6)
//   PUKE_ADDR_W  : width of a {bank, set} puke address (7)
//   SETS_TOTAL   : bank/set indices walked by a full flush (128)
//   puke_state_e : scheduler FSM state, also exported on the debug port
//   flush_map    : flush index -> {bank, set}, interleaving even/odd banks
package dcache1_puke_sched_pkg;

  localparam int PUKE_PORTS  = 6;
  localparam int PUKE_ADDR_W = 7;
  localparam int SETS_TOTAL  = 128;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRAIN_F = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_DONE    = 2'd3
  } puke_state_e;

  // Index bit 0 selects the bank so consecutive indices alternate banks.
  function automatic logic [PUKE_ADDR_W-1:0] flush_map(input logic [PUKE_ADDR_W-1:0] i);
    return {i[0], i[PUKE_ADDR_W-1:1]};
  endfunction

endpackage

// File: rtl/dcache1_puke_rr_arb.sv
// NREQ-way round-robin arbiter with one-hot grant.
//   clk, rst  : clock (state on negedge), synchronous active-high reset
//   req_i     : request vector
//   en_i      : grant allowed this cycle
//   gnt_o     : one-hot grant (zero when en_i low or no request)
//   gnt_idx_o : index of the winner (valid when gnt_any_o)
//   gnt_any_o : a grant is issued this cycle
// The pointer moves to winner+1 only when a grant is issued.
module dcache1_puke_rr_arb #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   gnt_idx_o,
  output logic            gnt_any_o
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] cand;
  logic          found;
  int            scan;

  // First requester at or after ptr_q, modulo NREQ.
  always_comb begin
    found     = 1'b0;
    gnt_idx_o = '0;
    scan      = 0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = (int'(ptr_q) + k) % NREQ;
      cand = PW'(scan);
      if (!found && req_i[cand]) begin
        found     = 1'b1;
        gnt_idx_o = cand;
      end
    end
  end

  always_comb begin
    gnt_o     = '0;
    gnt_any_o = en_i && found;
    ptr_d     = ptr_q;
    if (gnt_any_o) begin
      gnt_o[gnt_idx_o] = 1'b1;
      ptr_d = (gnt_idx_o == PW'(NREQ - 1)) ? '0 : gnt_idx_o + 1'b1;
    end
  end

  always_ff @(negedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dcache1_puke_sched.sv
// dcache1 puke scheduler: arbitrates invalidate requests into a FIFO, drains
// up to NPORT entries per cycle onto the shared puke ports, and sequences a
// full-cache flush over all bank/set indices.
//   clk, rst    : clock (all state on negedge), synchronous active-high reset
//   req_valid   : per-requester invalidate request
//   req_addr    : per-requester {bank, set}, requester i at [7i+6:7i]
//   req_ready   : one-hot grant; request consumed when valid & ready
//   flush_start : pulse, starts a full flush (ignored unless idle)
//   flush_busy  : high while draining for or walking a flush
//   flush_done  : one-cycle pulse after the last flush beat
//   puke_en     : per-port invalidate enable
//   puke_addr   : per-port {bank, set}, port k at [7k+6:7k]
//   fifo_count  : FIFO occupancy
//   dbg_state   : FSM state
// Build option: DCACHE1_PUKE_DEDUP_EN drops a granted request whose address
// already sits in the FIFO (handshake still completes).
// Puke outputs decode only registered state (FIFO head / flush index), so a
// request pushed in cycle t appears on the ports in cycle t+1.
module dcache1_puke_sched
  import dcache1_puke_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DEPTH = 16,
  parameter int NPORT = PUKE_PORTS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ*PUKE_ADDR_W-1:0]   req_addr,
  output logic [NREQ-1:0]               req_ready,
  input  logic                          flush_start,
  output logic                          flush_busy,
  output logic                          flush_done,
  output logic [NPORT-1:0]              puke_en,
  output logic [NPORT*PUKE_ADDR_W-1:0]  puke_addr,
  output logic [$clog2(DEPTH):0]        fifo_count,
  output puke_state_e                   dbg_state
);

  localparam int AW = PUKE_ADDR_W;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NW = $clog2(NPORT + 1);
  localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;

  puke_state_e   state_q, state_d;
  logic [AW-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] idx_q, idx_d;

  logic [AW-1:0] req_addr_a [NREQ];
  logic [RW-1:0] win_idx;
  logic [AW-1:0] win_addr;
  logic          gnt_any;
  logic          arb_en;
  logic          full;
  logic          dup_hit;
  logic          push;
  logic [NW-1:0] pop_n;
  logic [7:0]    fidx;
  logic          last_beat;

  always_comb begin
    for (int i = 0; i < NREQ; i++) req_addr_a[i] = req_addr[i*AW +: AW];
  end

  assign full   = (count_q == CW'(DEPTH));
  assign arb_en = (state_q == ST_IDLE) && !full;

  dcache1_puke_rr_arb #(.NREQ(NREQ), .PW(RW)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_valid),
    .en_i      (arb_en),
    .gnt_o     (req_ready),
    .gnt_idx_o (win_idx),
    .gnt_any_o (gnt_any)
  );

  assign win_addr = req_addr_a[win_idx];

`ifdef DCACHE1_PUKE_DEDUP_EN
  // Entries being popped this cycle are still counted in count_q, so they
  // are covered by the same comparison.
  always_comb begin
    dup_hit = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count_q) && (mem_q[rd_ptr_q + PW'(k)] == win_addr)) dup_hit = 1'b1;
    end
  end
`else
  assign dup_hit = 1'b0;
`endif

  assign push = gnt_any && !dup_hit;

  // Pop count is based on count_q, so an entry pushed this cycle never pops.
  always_comb begin
    pop_n = '0;
    if (state_q == ST_IDLE || state_q == ST_DRAIN_F)
      pop_n = (count_q > CW'(NPORT)) ? NW'(NPORT) : NW'(count_q);
  end

  always_comb begin
    puke_en   = '0;
    puke_addr = '0;
    fidx      = '0;
    if (state_q == ST_FLUSH) begin
      for (int k = 0; k < NPORT; k++) begin
        fidx = {1'b0, idx_q} + 8'(k);
        if (fidx < 8'(SETS_TOTAL)) begin
          puke_en[k]              = 1'b1;
          puke_addr[k*AW +: AW]   = flush_map(fidx[AW-1:0]);
        end
      end
    end else begin
      for (int k = 0; k < NPORT; k++) begin
        if (NW'(k) < pop_n) begin
          puke_en[k]            = 1'b1;
          puke_addr[k*AW +: AW] = mem_q[rd_ptr_q + PW'(k)];
        end
      end
    end
  end

  assign last_beat = ({1'b0, idx_q} + 8'(NPORT)) >= 8'(SETS_TOTAL);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rd_ptr_d = rd_ptr_q + PW'(pop_n);
    wr_ptr_d = wr_ptr_q + PW'(push);
    count_d  = count_q + CW'(push) - CW'(pop_n);
    case (state_q)
      ST_IDLE:    if (flush_start) state_d = ST_DRAIN_F;
      ST_DRAIN_F: begin
        if (count_q == '0) begin
          state_d = ST_FLUSH;
          idx_d   = '0;
        end
      end
      ST_FLUSH: begin
        if (last_beat) state_d = ST_DONE;
        else           idx_d   = idx_q + AW'(NPORT);
      end
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      if (push) mem_q[wr_ptr_q] <= win_addr;
    end
  end

  assign flush_busy = (state_q != ST_IDLE);
  assign flush_done = (state_q == ST_DONE);
  assign fifo_count = count_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/dcache1_puke_sched.md
Name: dcache1_puke_sched

Overview:
- Schedules set invalidations ("puke") into the dcache1 tag valid arrays.
- Collects invalidate requests from NREQ sources (snoop, store-conditional fail, TLB shootdown, flush) and arbitrates them round-robin into a 16-entry FIFO.
- Drains the FIFO onto the 6 puke write ports shared by every dcache1_tag way instance.
- Also sequences a full-cache flush that walks all 128 bank/set indices.

Parameters:
- NREQ, 4, number of invalidate requesters.
- DEPTH, 16, FIFO entries; power of two.
- NPORT, 6, puke ports driven per cycle; fixed by the tag valid RAM port count.

Ports:
- clk  in  1  clock; all state updates on negedge clk, matching the tag arrays.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester invalidate request.
- req_addr  in  NREQ*7  per-requester {bank(odd=1), set[5:0]}; requester i uses bits [7i+6:7i].
- req_ready  out  NREQ  grant; the request is consumed in the cycle where valid&ready.
- flush_start  in  1  pulse; starts a full flush.
- flush_busy  out  1  high while a flush is walking.
- flush_done  out  1  one-cycle pulse after the last flush beat.
- puke_en  out  6  per-port invalidate enable to the tag ways.
- puke_addr  out  6*7  per-port {bank, set}; port k uses bits [7k+6:7k].
- fifo_count  out  5  current occupancy, 0..16.

Behaviour:
- Reset: FIFO empty, rr pointer=0, flush idle. Outputs after reset: puke_en=0, puke_addr=0, req_ready=0, flush_busy=0, flush_done=0, fifo_count=0.
- Arbitration:
  - At most one push per cycle.
  - The grant goes to the first valid requester at or after rr_ptr, scanning modulo NREQ.
  - req_ready is combinational: high only for the winner, and only if the FIFO is not full and the state is IDLE.
  - After a grant, rr_ptr = winner+1 (mod NREQ). rr_ptr is unchanged when there is no grant.
- Drain:
  - Each cycle in IDLE, pop n = min(fifo_count, 6) entries. Entries are placed on ports 0..n-1 in FIFO order; puke_en has bits 0..n-1 set.
  - Outputs are registered, so a request is visible on puke ports 1 cycle after its handshake if the FIFO was empty. Minimum latency is therefore 1 cycle.
- Simultaneous push and pop:
  - fifo_count_next = count + push - n.
  - An entry pushed this cycle is not popped this cycle.
  - Full means count==16; a full FIFO still pops in the same cycle, but no push is accepted that cycle.
- Pointers: 4-bit read/write pointers wrap modulo DEPTH. The read pointer advances by n mod 16.
- FSM states: IDLE, DRAIN_F, FLUSH, DONE.
  - IDLE: flush_start moves to DRAIN_F.
  - DRAIN_F: req_ready is held 0 and the FIFO keeps draining. When count==0, move to FLUSH with idx=0.
  - FLUSH: each cycle issues indices idx..idx+5 on ports 0..5, then idx+=6. On the last beat idx=126, only ports 0,1 are enabled (126,127), then move to DONE. A flush is 22 beats.
  - DONE: flush_done=1 for one cycle, then return to IDLE.
  - flush_busy=1 in DRAIN_F, FLUSH and DONE.
- Flush index mapping: index i drives puke_addr = {i[0], i[6:1]}, so even and odd banks are interleaved.
- flush_start while not in IDLE is ignored.
- Reset mid-flush or mid-drain: synchronous reset returns to IDLE and drops FIFO contents. No puke_en is driven in the cycle after reset.
- Duplicate addresses within one drain cycle are allowed; the tag RAM write-collision result is 0 either way.

Optional Feature:
- DCACHE1_PUKE_DEDUP_EN defined:
  - Before a push, the winner's addr is compared against all valid FIFO entries and the entries being popped this cycle.
  - On a match, req_ready=1 but nothing is pushed and the count is unchanged.
- Undefined: every granted request is pushed; no comparators are built.

Decomposition:
- Shared package, added to struct.sv:
  - `dcache1_puke_ports (6)
  - `dcache1_puke_addr_width (7)
  - `dcache1_sets_total (128)
  - FSM state encoding (2 bits).
- One sub-module: dcache1_puke_rr_arb, an NREQ-way round-robin one-hot grant with pointer update.
- FIFO and pop-count logic stay inline.

Test Plan:
- Single request: req0 addr 7'h45 -> req_ready[0]=1; next cycle puke_en=6'b000001, port0=7'h45; fifo_count back to 0.
- All 4 requesters valid for 3 cycles with rr_ptr=2:
  - grants go 2,3,0 in order;
  - entries drain in the same order, one per cycle, 1 cycle later.
- Fill to 16 with flush stalled behind DRAIN_F, then release:
  - pops are 6,6,4 over 3 cycles;
  - fifo_count goes 16->10->4->0;
  - no push is accepted while full.
- flush_start with 3 entries queued:
  - 1 drain beat, then 22 flush beats;
  - the first beat drives 0x00,0x40,0x01,0x41,0x02,0x42;
  - the last beat enables 2 ports only (0x3F, 0x7F);
  - one cycle of flush_done;
  - req_ready=0 throughout.
- rst asserted on flush beat 10 -> next cycle all outputs 0, FSM IDLE, fifo_count=0.
- DEDUP_EN: same addr 7'h12 from req1 twice while the first copy is still queued -> second handshake completes; fifo_count rises by 1 only.
